code_word_decoder: RTL
======================

Name: code_word_decoder

Overview:
- Inverse of the team's 3-bit to 7-bit code encoder: takes a 7-bit Gray or one-hot code word and recovers the 3-bit value.
- Registered single-stage pipeline with valid/ready handshakes on both sides.
- Flags and counts illegal code words.
- Sits on the receive side of any link that carries encoded 3-bit symbols.

Parameters:
- USE_GRAY, 1, 1 = decode Gray (code in bits [2:0]); 0 = decode one-hot.
- ERR_CNT_W, 8, width of the saturating illegal-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  code word on in_code is valid
- in_ready  output  1  decoder can accept a word this cycle
- in_code  input  7  encoded word
- out_valid  output  1  out_value/out_err hold a decoded result
- out_ready  input  1  downstream accepts the result this cycle
- out_value  output  3  decoded value
- out_err  output  1  result came from an illegal word
- err_sticky  output  1  set by any accepted illegal word; cleared by err_clr or rst
- err_count  output  ERR_CNT_W  saturating count of accepted illegal words
- err_clr  input  1  synchronous clear of err_sticky and err_count

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_value=0, out_err=0, err_sticky=0, err_count=0. rst overrides every other input and drops any in-flight result.
- in_ready = !out_valid || out_ready. This is combinational, so full throughput is one word per cycle.
- Accept occurs when in_valid && in_ready. On the next edge: out_valid=1, out_value and out_err are loaded. Latency is 1 cycle.
- Output handshake: out_valid && out_ready with no accept gives out_valid=0 next cycle. Accept and drain in the same cycle replaces the result with no bubble.
- While out_valid && !out_ready: out_value and out_err hold stable; in_ready=0.
- Gray decode (USE_GRAY=1):
  - v2=c2, v1=c2^c1, v0=c2^c1^c0.
  - Illegal if c[6:3]!=0. out_value is still the decode of c[2:0].
- One-hot decode (USE_GRAY=0):
  - 0000000 decodes to 0.
  - A single bit k set (k=0..6) decodes to k+1.
  - Illegal if more than one bit is set; out_value=0, out_err=1.
- Error accounting is updated only on accept of an illegal word:
  - err_sticky is set.
  - err_count increments, saturating at all-ones with no wrap.
- Simultaneous err_clr and illegal accept: the clear wins, and the count does not include the new error. out_err is still set on that result.
- No internal states beyond the output register and error counters. The FSM is implicit: EMPTY (out_valid=0) or FULL (out_valid=1).

Optional Feature:
- Macro: CODE_DEC_PASSTHRU_ERR_EN.
- Defined: the illegal word is retained in an extra 7-bit output, out_raw, loaded together with out_value. Otherwise out_raw=0. Reset value is 0.
- Undefined: port out_raw does not exist, and no raw-capture register is built.

Decomposition:
- Package code_pkg holds:
  - constants CODE_W=7, VAL_W=3
  - function gray_to_bin(3-bit)
  - function onehot_to_bin(7-bit) returning value and error flag
- Sub-module code_word_check (combinational classifier): in_code in, value and illegal flag out, parameterised by USE_GRAY.
- The top level holds the handshake register and the error counters.

Test Plan:
- USE_GRAY=1, out_ready=1, feed 000, 001, 011, 010, 110, 111, 101, 100 back-to-back -> out_value is 0..7 one cycle later, out_err=0, no bubbles.
- USE_GRAY=0, feed 0000000, 0000001, 1000000, then 0000110 -> out_value 0, 1, 7, then 0 with out_err=1; err_count=1, err_sticky=1.
- out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, out_value held stable; release -> next word taken the same cycle with no loss or duplication.
- ERR_CNT_W=2, inject 5 illegal words -> err_count saturates at 3; err_clr pulsed in the same cycle as an illegal accept -> err_count=0, err_sticky=0, out_err=1.
- rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, in_ready=1, all counters 0.
- CODE_DEC_PASSTHRU_ERR_EN defined, USE_GRAY=1, in_code=1010011 -> out_err=1, out_value=2, out_raw=1010011.

Source files
------------

// File: rtl/code_pkg.sv
// Shared constants and decode helpers for the 3-bit symbol code family.
// Contents:
//   CODE_W, VAL_W   - code word and value widths
//   dec_t           - decoded value plus illegal flag
//   gray_to_bin     - 3-bit Gray to binary
//   onehot_to_bin   - 7-bit one-hot (or all-zero) to value, flags multi-hot
package code_pkg;
  localparam int CODE_W = 7;
  localparam int VAL_W  = 3;

  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic             err;
  } dec_t;

  function automatic logic [VAL_W-1:0] gray_to_bin(input logic [VAL_W-1:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  // All-zero maps to 0, bit k alone maps to k+1, anything else is illegal
  // and reports value 0.
  function automatic dec_t onehot_to_bin(input logic [CODE_W-1:0] c);
    dec_t             res;
    logic [VAL_W-1:0] n;
    res = '0;
    n   = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (c[i]) begin
        n         = n + 3'd1;
        res.value = VAL_W'(i + 1);
      end
    end
    if (n > 3'd1) begin
      res.value = '0;
      res.err   = 1'b1;
    end
    return res;
  endfunction
endpackage

// File: rtl/code_word_check.sv
// Combinational classifier for one code word.
// Ports:
//   i_code    - 7-bit code word
//   o_value   - recovered 3-bit value
//   o_illegal - word is not a legal code word
// Parameter USE_GRAY: 1 = Gray in bits [2:0] (upper bits must be 0), 0 = one-hot.
module code_word_check
  import code_pkg::*;
#(
  parameter int USE_GRAY = 1
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [VAL_W-1:0]  o_value,
  output logic              o_illegal
);
  generate
    if (USE_GRAY != 0) begin : g_gray
      // Value is still decoded from the low bits even when upper bits are set.
      assign o_value   = gray_to_bin(i_code[VAL_W-1:0]);
      assign o_illegal = |i_code[CODE_W-1:VAL_W];
    end else begin : g_onehot
      dec_t w_dec;
      assign w_dec     = onehot_to_bin(i_code);
      assign o_value   = w_dec.value;
      assign o_illegal = w_dec.err;
    end
  endgenerate
endmodule

// File: rtl/code_word_decoder.sv
// Single-stage registered decoder from 7-bit code word to 3-bit value with
// valid/ready on both sides, illegal-word flag, sticky error and saturating
// error counter.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake, in_code carries the word
//   out_valid/out_ready - output handshake, out_value/out_err carry the result
//   err_sticky          - set by any accepted illegal word
//   err_count           - saturating count of accepted illegal words
//   err_clr             - synchronous clear of err_sticky/err_count (wins over a new error)
//   out_raw             - only with CODE_DEC_PASSTHRU_ERR_EN: the illegal word, else 0
// Build option: define CODE_DEC_PASSTHRU_ERR_EN to add out_raw.
module code_word_decoder
  import code_pkg::*;
#(
  parameter int USE_GRAY  = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VAL_W-1:0]     out_value,
  output logic                 out_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
`ifdef CODE_DEC_PASSTHRU_ERR_EN
  output logic [CODE_W-1:0]    out_raw,
`endif
  input  logic                 err_clr
);
  logic [VAL_W-1:0]     w_value;
  logic                 w_illegal;
  logic                 w_acc;
  logic                 r_valid;
  logic [VAL_W-1:0]     r_value;
  logic                 r_err;
  logic                 r_sticky;
  logic [ERR_CNT_W-1:0] r_count;

  code_word_check #(.USE_GRAY(USE_GRAY)) u_check (
    .i_code    (in_code),
    .o_value   (w_value),
    .o_illegal (w_illegal)
  );

  // Register frees up in the same cycle it drains, so no bubble.
  assign in_ready = !r_valid || out_ready;
  assign w_acc    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_value <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_value <= w_value;
      r_err   <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (w_acc && w_illegal) begin
      r_sticky <= 1'b1;
      if (r_count != '1) r_count <= r_count + ERR_CNT_W'(1);
    end
  end

`ifdef CODE_DEC_PASSTHRU_ERR_EN
  logic [CODE_W-1:0] r_raw;
  always_ff @(posedge clk) begin
    if (rst)        r_raw <= '0;
    else if (w_acc) r_raw <= w_illegal ? in_code : '0;
  end
  assign out_raw = r_raw;
`endif

  assign out_valid  = r_valid;
  assign out_value  = r_value;
  assign out_err    = r_err;
  assign err_sticky = r_sticky;
  assign err_count  = r_count;
endmodule
